dmem_load_store_unit: RTL and testbench

- Memory-stage data-memory access unit for the RV32I 5-stage pipeline.
- Turns each load/store in M into a handshaked bus transaction and stalls the pipeline until it completes.
- Returns load data byte-lane extracted and sign/zero-extended as ReadDataM, which the MEM/WB register carries to writeback as ReadDataW.

---
 rtl/dmem_load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_dmem_load_store_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_load_store_unit.sv
// RV32I M-stage load/store unit: one handshaked bus transaction per memory op, stalling the pipe until done.
// Optional DMEM_TIMEOUT_EN adds a REQ/RESP watchdog that aborts with a BusErrM pulse.
module dmem_load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state;
    logic [2:0]  f3Q;
    logic [1:0]  offQ;
    logic        legalF3, aligned, accept, badReq, tmoHit;
    logic [3:0]  beNext;
    logic [31:0] wdNext, fmtData;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        legalF3 = 1'b0;
        case (funct3M)
            3'b000, 3'b001, 3'b010: legalF3 = 1'b1;
            3'b100, 3'b101:         legalF3 = !MemWriteM;
            default:                legalF3 = 1'b0;
        endcase
        aligned = 1'b1;
        case (funct3M[1:0])
            2'b01:   aligned = !ALUResultM[0];
            2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        beNext = 4'b1111;
        wdNext = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                beNext = 4'b0001 << ALUResultM[1:0];
                wdNext = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                beNext = 4'b0011 << ALUResultM[1:0];
                wdNext = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    assign accept = (state == IDLE) && MemReqM && legalF3 && aligned;
    assign badReq = (state == IDLE) && MemReqM && !(legalF3 && aligned);
    // Gate with rst so a request held high during reset never stalls the pipe.
    assign StallM = rst && (accept || (state == REQ) || (state == RESP));

    always_comb begin
        byteSel = dmem_rdata[8*offQ +: 8];
        halfSel = offQ[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3Q)
            3'b000:  fmtData = {{24{byteSel[7]}}, byteSel};
            3'b100:  fmtData = {24'd0, byteSel};
            3'b001:  fmtData = {{16{halfSel[15]}}, halfSel};
            3'b101:  fmtData = {16'd0, halfSel};
            default: fmtData = dmem_rdata;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] tmoCnt;
    logic            busErrQ;

    // Fires on the TIMEOUT_CYCLES-th REQ/RESP cycle unless that cycle completes the handshake.
    assign tmoHit = ((state == REQ && !dmem_gnt) || (state == RESP && !dmem_rvalid)) &&
                    (tmoCnt == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmoCnt  <= '0;
            busErrQ <= 1'b0;
        end else begin
            busErrQ <= tmoHit;
            tmoCnt  <= (state == REQ || state == RESP) ? tmoCnt + 1'b1 : '0;
        end
    end
    assign BusErrM = busErrQ;
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT_CYCLES == 0);
    assign tmoHit  = 1'b0;
    assign BusErrM = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            f3Q        <= '0;
            offQ       <= '0;
            ReadDataM  <= '0;
            MisalignM  <= 1'b0;
        end else begin
            MisalignM <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWriteM;
                        dmem_addr  <= {ALUResultM[31:2], 2'b00};
                        dmem_wdata <= wdNext;
                        dmem_be    <= beNext;
                        f3Q        <= funct3M;
                        offQ       <= ALUResultM[1:0];
                        state      <= REQ;
                    end else if (badReq) begin
                        MisalignM <= 1'b1;
                        ReadDataM <= '0;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        state    <= dmem_we ? DONE : RESP;
                    end else if (tmoHit) begin
                        dmem_req  <= 1'b0;
                        ReadDataM <= '0;
                        state     <= DONE;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        ReadDataM <= fmtData;
                        state     <= DONE;
                    end else if (tmoHit) begin
                        ReadDataM <= '0;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_load_store_unit.sv
// Randomized self-checking bench for dmem_load_store_unit with an arithmetic reference model.
module tb_dmem_load_store_unit;
`ifdef DMEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemReqM = 1'b0, MemWriteM = 1'b0;
    logic [2:0]  funct3M = '0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic        StallM, MisalignM, BusErrM;
    logic [31:0] ReadDataM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int nCmp = 0, nErr = 0;
    logic [31:0] expRd = '0;

    always #5 clk = ~clk;

    dmem_load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .MemReqM(MemReqM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .StallM(StallM), .ReadDataM(ReadDataM),
        .MisalignM(MisalignM), .BusErrM(BusErrM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    // ---------------- reference model ----------------
    function automatic int sizeOf(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit legalOf(input bit we, input logic [2:0] f3);
        if (we) return f3 inside {3'd0, 3'd1, 3'd2};
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic bit alignedOf(input logic [2:0] f3, input logic [31:0] a);
        return (a % sizeOf(f3)) == 0;
    endfunction

    function automatic logic [3:0] beOf(input logic [2:0] f3, input logic [31:0] a);
        int n = sizeOf(f3);
        if (n == 4) return 4'hF;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] wdOf(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n = sizeOf(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ldOf(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
        int n = sizeOf(f3);
        logic [63:0] full, v;
        full = 64'd1 << (8 * n);
        v = ({32'd0, rdata} >> (8 * (a % 4))) & (full - 64'd1);
        if (!f3[2] && n < 4 && v[8*n-1]) v = v - full;
        return v[31:0];
    endfunction

    // ---------------- bus/pipeline driver (observes, does not judge) ----------------
    task automatic doAccess(input bit we, input logic [2:0] f3, input logic [31:0] a, wd, rd,
                            input int gntDly, rvDly,
                            output int stallCnt, output int reqCnt,
                            output logic [31:0] rAddr, output logic [31:0] rWd,
                            output logic [3:0] rBe, output logic rWe, output bit stable,
                            output logic [31:0] doneRd, output logic doneErr,
                            output logic postMis, output logic [31:0] postRd,
                            output logic postErr, output logic postReq, output bit hung);
        int cyc = 0;
        int rvCnt = -1;
        bit fin = 0;
        stallCnt = 0; reqCnt = 0; stable = 1; hung = 0;
        rAddr = '0; rWd = '0; rBe = '0; rWe = 1'b0; doneRd = '0; doneErr = 1'b0;
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = we; funct3M = f3; ALUResultM = a; WriteDataM = wd; dmem_rdata = rd;
        while (!fin) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (rvCnt == 0) dmem_rvalid = 1'b1;
            if (rvCnt >= 0) rvCnt--;
            if (dmem_req) begin
                if (reqCnt == 0) begin
                    rAddr = dmem_addr; rWd = dmem_wdata; rBe = dmem_be; rWe = dmem_we;
                end else if (dmem_addr !== rAddr || dmem_wdata !== rWd || dmem_be !== rBe || dmem_we !== rWe) begin
                    stable = 0;
                end
                if (reqCnt >= gntDly) begin
                    dmem_gnt = 1'b1;
                    if (!we) rvCnt = rvDly;
                end
                reqCnt++;
            end
            #1;
            if (StallM) stallCnt++;
            else begin fin = 1; doneRd = ReadDataM; doneErr = BusErrM; end
            cyc++;
            if (!fin && cyc >= 200) begin hung = 1; fin = 1; end
            @(negedge clk);
        end
        MemReqM = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1;
        postMis = MisalignM; postRd = ReadDataM; postErr = BusErrM; postReq = dmem_req;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        MemReqM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h40;
        #12;
        nCmp++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, ReadDataM, MisalignM, BusErrM} !== '0) begin
            nErr++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h be=%b rd=%h mis=%b err=%b, need all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, ReadDataM, MisalignM, BusErrM);
        end
        nCmp++;
        if (StallM !== 1'b0) begin nErr++; $display("FAIL reset_stall: got %b need 0", StallM); end
        @(negedge clk);
        MemReqM = 1'b0; rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        int sc, rc; logic [31:0] ra, rw, drd, prd; logic [3:0] rb; logic rwe, de, pm, pe, pq; bit st, hg;
        doAccess(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, sc, rc, ra, rw, rb, rwe, st, drd, de, pm, prd, pe, pq, hg);
        expRd = 32'hDEADBEEF;
        nCmp++; if (hg) begin nErr++; $display("FAIL lw_complete: no DONE within bound"); end
        nCmp++; if ({ra, rb, rwe} !== {32'h100, 4'hF, 1'b0}) begin nErr++;
            $display("FAIL lw_bus: addr=%h be=%b we=%b need 00000100/1111/0", ra, rb, rwe); end
        nCmp++; if (sc != 3) begin nErr++; $display("FAIL lw_stall: got %0d cycles need 3", sc); end
        nCmp++; if (drd !== expRd) begin nErr++; $display("FAIL lw_data: got %h need %h", drd, expRd); end
    endtask

    task automatic test_lb_lbu();
        int sc, rc; logic [31:0] ra, rw, drd, prd; logic [3:0] rb; logic rwe, de, pm, pe, pq; bit st, hg;
        doAccess(0, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 0, 0, sc, rc, ra, rw, rb, rwe, st, drd, de, pm, prd, pe, pq, hg);
        nCmp++; if ({ra, rb} !== {32'h200, 4'b1000}) begin nErr++;
            $display("FAIL lb_bus: addr=%h be=%b need 00000200/1000", ra, rb); end
        nCmp++; if (drd !== 32'hFFFFFF80) begin nErr++; $display("FAIL lb_data: got %h need ffffff80", drd); end
        doAccess(0, 3'b100, 32'h203, 32'h0, 32'h80FF_1234, 0, 0, sc, rc, ra, rw, rb, rwe, st, drd, de, pm, prd, pe, pq, hg);
        expRd = 32'h80;
        nCmp++; if (drd !== expRd) begin nErr++; $display("FAIL lbu_data: got %h need %h", drd, expRd); end
    endtask

    task automatic test_sh();
        int sc, rc; logic [31:0] ra, rw, drd, prd; logic [3:0] rb; logic rwe, de, pm, pe, pq; bit st, hg;
        doAccess(1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 0, 0, sc, rc, ra, rw, rb, rwe, st, drd, de, pm, prd, pe, pq, hg);
        nCmp++; if ({ra, rw, rb, rwe} !== {32'h300, 32'hABCDABCD, 4'b1100, 1'b1}) begin nErr++;
            $display("FAIL sh_bus: addr=%h wd=%h be=%b we=%b need 00000300/abcdabcd/1100/1", ra, rw, rb, rwe); end
        nCmp++; if (sc != 2) begin nErr++; $display("FAIL sh_stall: got %0d cycles need 2", sc); end
        nCmp++; if (drd !== expRd || prd !== expRd) begin nErr++;
            $display("FAIL sh_readdata_kept: got %h/%h need %h", drd, prd, expRd); end
    endtask

    task automatic test_misalign();
        int sc, rc; logic [31:0] ra, rw, drd, prd; logic [3:0] rb; logic rwe, de, pm, pe, pq; bit st, hg;
        doAccess(0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, sc, rc, ra, rw, rb, rwe, st, drd, de, pm, prd, pe, pq, hg);
        expRd = '0;
        nCmp++; if (rc != 0 || sc != 0) begin nErr++;
            $display("FAIL mis_no_bus: req cycles=%0d stall cycles=%0d need 0/0", rc, sc); end
        nCmp++; if (pm !== 1'b1 || prd !== expRd) begin nErr++;
            $display("FAIL mis_flag: mis=%b rd=%h need 1/%h", pm, prd, expRd); end
        @(negedge clk); #1;
        nCmp++; if (MisalignM !== 1'b0) begin nErr++; $display("FAIL mis_pulse: still %b need 0", MisalignM); end
        doAccess(1, 3'b100, 32'h104, 32'h55, 32'h0, 0, 0, sc, rc, ra, rw, rb, rwe, st, drd, de, pm, prd, pe, pq, hg);
        nCmp++; if (rc != 0 || pm !== 1'b1) begin nErr++;
            $display("FAIL illegal_store_f3: req cycles=%0d mis=%b need 0/1", rc, pm); end
    endtask

    task automatic test_gnt_wait();
        int sc, rc; logic [31:0] ra, rw, drd, prd; logic [3:0] rb; logic rwe, de, pm, pe, pq; bit st, hg;
        int dly = (TMO >= 16) ? 5 : TMO - 2;
        logic [31:0] wd = $urandom;
        doAccess(1, 3'b010, 32'h400, wd, 32'h0, dly, 0, sc, rc, ra, rw, rb, rwe, st, drd, de, pm, prd, pe, pq, hg);
        nCmp++; if (!st || rc != dly + 1) begin nErr++;
            $display("FAIL gnt_wait_hold: stable=%0d req cycles=%0d need 1/%0d", st, rc, dly + 1); end
        nCmp++; if ({ra, rw, rb} !== {32'h400, wd, 4'hF} || sc != dly + 2) begin nErr++;
            $display("FAIL gnt_wait_bus: addr=%h wd=%h be=%b stall=%0d need 00000400/%h/1111/%0d", ra, rw, rb, sc, wd, dly + 2); end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int sc, rc; logic [31:0] ra, rw, drd, prd; logic [3:0] rb; logic rwe, de, pm, pe, pq; bit st, hg;
        doAccess(1, 3'b010, 32'h600, 32'h1, 32'h0, 1000, 0, sc, rc, ra, rw, rb, rwe, st, drd, de, pm, prd, pe, pq, hg);
        expRd = '0;
        nCmp++; if (hg || rc != TMO || sc != TMO + 1) begin nErr++;
            $display("FAIL timeout_abort: hung=%0d req cycles=%0d stall=%0d need 0/%0d/%0d", hg, rc, sc, TMO, TMO + 1); end
        nCmp++; if (de !== 1'b1 || drd !== 32'h0 || pe !== 1'b0 || pq !== 1'b0) begin nErr++;
            $display("FAIL timeout_flag: err=%b rd=%h postErr=%b postReq=%b need 1/0/0/0", de, drd, pe, pq); end
    endtask
`endif

    task automatic test_random();
        int sc, rc; logic [31:0] ra, rw, drd, prd; logic [3:0] rb; logic rwe, de, pm, pe, pq; bit st, hg;
        for (int it = 0; it < 60; it++) begin
            bit we = 1'($urandom_range(0, 1));
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            logic [31:0] a = $urandom & 32'h0000_0FFF;
            logic [31:0] wd = $urandom, rd = $urandom;
            int gd, rv, expSc;
            bit ok;
            if (TMO >= 16) begin gd = $urandom_range(0, 3); rv = $urandom_range(0, 3); end
            else begin gd = $urandom_range(0, 1); rv = (gd == 0) ? $urandom_range(0, 1) : 0; end
            ok = legalOf(we, f3) && alignedOf(f3, a);
            doAccess(we, f3, a, wd, rd, gd, rv, sc, rc, ra, rw, rb, rwe, st, drd, de, pm, prd, pe, pq, hg);
            if (ok) begin
                if (!we) expRd = ldOf(f3, a, rd);
                expSc = we ? gd + 2 : gd + rv + 3;
                nCmp++; if (hg || {ra, rb, rwe} !== {a & 32'hFFFF_FFFC, beOf(f3, a), we} || sc != expSc) begin nErr++;
                    $display("FAIL rand_bus[%0d]: addr=%h be=%b we=%b stall=%0d need %h/%b/%b/%0d",
                             it, ra, rb, rwe, sc, a & 32'hFFFF_FFFC, beOf(f3, a), we, expSc); end
                if (we) begin
                    nCmp++; if (rw !== wdOf(f3, wd)) begin nErr++;
                        $display("FAIL rand_wdata[%0d]: got %h need %h", it, rw, wdOf(f3, wd)); end
                end
                nCmp++; if (drd !== expRd || de !== 1'b0 || pm !== 1'b0 || pq !== 1'b0) begin nErr++;
                    $display("FAIL rand_result[%0d] f3=%0d a=%h: rd=%h err=%b mis=%b postReq=%b need %h/0/0/0",
                             it, f3, a, drd, de, pm, pq, expRd); end
            end else begin
                expRd = '0;
                nCmp++; if (rc != 0 || sc != 0 || pm !== 1'b1 || prd !== expRd) begin nErr++;
                    $display("FAIL rand_misalign[%0d] we=%0d f3=%0d a=%h: req=%0d stall=%0d mis=%b rd=%h need 0/0/1/0",
                             it, we, f3, a, rc, sc, pm, prd); end
            end
        end
    endtask

    task automatic test_reset_in_resp();
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h500; dmem_rdata = 32'h0;
        @(negedge clk);
        dmem_gnt = dmem_req;
        @(negedge clk);
        dmem_gnt = 1'b0;
        nCmp++; if (StallM !== 1'b1 || dmem_req !== 1'b0) begin nErr++;
            $display("FAIL resp_state: stall=%b req=%b need 1/0", StallM, dmem_req); end
        #2 rst = 1'b0;
        #1;
        nCmp++; if ({StallM, dmem_req, dmem_be, ReadDataM, MisalignM, BusErrM} !== '0) begin nErr++;
            $display("FAIL reset_in_resp: stall=%b req=%b be=%b rd=%h mis=%b err=%b need all 0",
                     StallM, dmem_req, dmem_be, ReadDataM, MisalignM, BusErrM); end
        @(negedge clk);
        MemReqM = 1'b0; rst = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        nCmp++; if (ReadDataM !== 32'h0 || StallM !== 1'b0 || dmem_req !== 1'b0) begin nErr++;
            $display("FAIL late_rvalid: rd=%h stall=%b req=%b need 0/0/0", ReadDataM, StallM, dmem_req); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misalign();
        test_gnt_wait();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        test_reset_in_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", nCmp);
        $fatal(1);
    end
endmodule
